// File: rtl/fifo_feed_arbiter_if.sv
// Bundle of the reader-side and FIFO-side handshake signals of fifo_feed_arbiter.
// The master modport is the arbiter; the slave modport is the readers/FIFO environment.
interface fifo_feed_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       src_req;
    logic [WIDTH-1:0] src_data0;
    logic [WIDTH-1:0] src_data1;
    logic [WIDTH-1:0] src_data2;
    logic [2:0]       src_cen;
    logic [2:0]       src_restart;
    logic             rewind;
    logic             fifo_rd;
    logic             fifo_wr;
    logic [WIDTH-1:0] fifo_din;
    logic [1:0]       fifo_src;
    logic             busy;

    modport master (
        input  src_req, src_data0, src_data1, src_data2, rewind, fifo_rd,
        output src_cen, src_restart, fifo_wr, fifo_din, fifo_src, busy
    );

    modport slave (
        output src_req, src_data0, src_data1, src_data2, rewind, fifo_rd,
        input  src_cen, src_restart, fifo_wr, fifo_din, fifo_src, busy
    );
endinterface

// File: rtl/fifo_feed_arbiter.sv
// Round-robin scheduler sharing one FIFO write port between three stimulus readers,
// with a credit counter that mirrors FIFO occupancy so a full queue is never written.
module fifo_feed_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    fifo_feed_arbiter_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [3:0]    LAST_BEAT = 4'(BURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_RESTART} state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       beat_q, beat_d;
    logic [CW-1:0]    credits_q;
    logic             wr_q;
    logic [WIDTH-1:0] din_q;
    logic [1:0]       src_q;
    logic [2:0]       cen;
    logic [2:0]       restart;
    logic [WIDTH-1:0] sel_data;
    logic             inc, dec;

    // First requester strictly after `last`, wrapping; returns `last` only if it alone asks.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] pick;
        logic       found;
        int         c;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            c = (int'(last) + k) % 3;
            if (!found && req[c]) begin
                pick  = 2'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        cen     = 3'b000;
        restart = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (bus.rewind) begin
                    state_d = S_DRAIN;
                end else if (|bus.src_req) begin
                    grant_d = rr_pick(last_q, bus.src_req);
                    beat_d  = 4'd0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (bus.rewind) begin
                    last_d  = grant_q;
                    state_d = S_DRAIN;
                end else if (!bus.src_req[grant_q]) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else if (credits_q != '0) begin
                    cen[grant_q] = 1'b1;
                    beat_d       = beat_q + 4'd1;
                    if (beat_q == LAST_BEAT) begin
                        last_d  = grant_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                // The write for the final cen lands one cycle later; wait it out.
                if (!wr_q) state_d = S_RESTART;
            end
            S_RESTART: begin
                restart = 3'b111;
                last_d  = 2'd2;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (grant_q)
            2'd0:    sel_data = bus.src_data0;
            2'd1:    sel_data = bus.src_data1;
            default: sel_data = bus.src_data2;
        endcase
    end

    assign dec = |cen;
    assign inc = bus.fifo_rd && (credits_q != FULL);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'd0;
            last_q    <= 2'd2;
            beat_q    <= 4'd0;
            credits_q <= FULL;
            wr_q      <= 1'b0;
            din_q     <= '0;
            src_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            wr_q    <= dec;
            if (inc && !dec)      credits_q <= credits_q + ONE;
            else if (dec && !inc) credits_q <= credits_q - ONE;
            if (dec) begin
                din_q <= sel_data;
                src_q <= grant_q;
            end
        end
    end

    assign bus.src_cen     = cen;
    assign bus.src_restart = restart;
    assign bus.fifo_wr     = wr_q;
    assign bus.fifo_din    = din_q;
    assign bus.fifo_src    = src_q;
    assign bus.busy        = (state_q != S_IDLE) || wr_q;
endmodule

// File: tb/tb_fifo_feed_arbiter.sv
// Self-checking bench for fifo_feed_arbiter: directed scenarios plus randomized loads
// checked against a transaction-level round-robin write-order model and FIFO occupancy.
module tb_fifo_feed_arbiter;
    localparam int DEPTH = 16;
    localparam int BURST = 4;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset;

    fifo_feed_arbiter_if #(.WIDTH(32)) bus ();

    fifo_feed_arbiter #(.WIDTH(32), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          ptr[3];
    int          len[3];
    logic [31:0] tag[3];

    // Reader model: word = tag + index, request while words remain.
    always_comb begin
        bus.src_data0 = tag[0] + 32'(ptr[0]);
        bus.src_data1 = tag[1] + 32'(ptr[1]);
        bus.src_data2 = tag[2] + 32'(ptr[2]);
        for (int i = 0; i < 3; i++) bus.src_req[i] = (ptr[i] < len[i]);
    end

    int   vectors;
    int   miscompares;
    wr_t  exp_q[$];
    int   occ, last_occ_pre, wr_count, model_last, last_credits;
    logic prev_cen_any, rd_mode, rst_req_cen, hit, last_busy;
    logic [2:0] last_cen, last_restart;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Expected write stream: round robin after the last grant, up to BURST words per grant.
    task automatic plan_writes();
        int  idx[3];
        int  g, c;
        wr_t w;
        for (int i = 0; i < 3; i++) idx[i] = ptr[i];
        while (1) begin
            g = -1;
            for (int k = 1; k <= 3; k++) begin
                c = (model_last + k) % 3;
                if (g < 0 && idx[c] < len[c]) g = c;
            end
            if (g < 0) break;
            for (int b = 0; b < BURST && idx[g] < len[g]; b++) begin
                w.src  = 2'(g);
                w.data = tag[g] + 32'(idx[g]);
                exp_q.push_back(w);
                idx[g]++;
            end
            model_last = g;
        end
    endtask

    task automatic push_exp(input int s, input int first, input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.src  = 2'(s);
            w.data = tag[s] + 32'(first + i);
            exp_q.push_back(w);
        end
    endtask

    task automatic tick();
        logic [2:0] cen, rs;
        wr_t        w;
        @(negedge clk);
        cen          = bus.src_cen;
        rs           = bus.src_restart;
        last_cen     = cen;
        last_restart = rs;
        last_busy    = bus.busy;
        last_credits = int'(dut.credits_q);
        last_occ_pre = occ;
        chk("cen_onehot", 64'($countones(cen) <= 1), 64'd1);
        chk("wr_latency", 64'(bus.fifo_wr), 64'(prev_cen_any));
        if (bus.fifo_wr) begin
            chk("wr_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("wr_src", 64'(bus.fifo_src), 64'(w.src));
                chk("wr_data", 64'(bus.fifo_din), 64'(w.data));
            end
            occ++;
            wr_count++;
        end
        if (bus.fifo_rd) occ--;
        chk("occupancy", 64'(occ >= 0 && occ <= DEPTH), 64'd1);
        if (rst_req_cen && cen == 3'b010) begin
            reset = 1'b1;
            hit   = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rs[i])       ptr[i] = 0;
            else if (cen[i]) ptr[i]++;
        end
        prev_cen_any = (|cen) && !reset;
        bus.fifo_rd  = rd_mode && (occ > 0) && ($urandom_range(0, 1) == 1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        @(negedge clk);
        chk({pfx, "_cen"}, 64'(bus.src_cen), 64'd0);
        chk({pfx, "_restart"}, 64'(bus.src_restart), 64'd0);
        chk({pfx, "_wr"}, 64'(bus.fifo_wr), 64'd0);
        chk({pfx, "_din"}, 64'(bus.fifo_din), 64'd0);
        chk({pfx, "_src"}, 64'(bus.fifo_src), 64'd0);
        chk({pfx, "_busy"}, 64'(bus.busy), 64'd0);
        chk({pfx, "_credits"}, 64'(dut.credits_q), 64'(DEPTH));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.rewind  = 1'b0;
        bus.fifo_rd = 1'b0;
        rd_mode     = 1'b0;
        rst_req_cen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ptr[i] = 0;
            len[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b0;
        exp_q.delete();
        occ          = 0;
        model_last   = 2;
        prev_cen_any = 1'b0;
        wr_count     = 0;
        check_reset_outputs("reset");
    endtask

    task automatic run_until_drained(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [9:0] trace;
        int         n;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 3; i++) tag[i] = 32'd0;
        do_reset();

        // Single source: six words, two bursts.
        tag[0] = 32'd1;
        len[0] = 6;
        plan_writes();
        for (int c = 0; c < 10; c++) begin
            tick();
            trace[c] = last_cen[0];
        end
        chk("single_cen_trace", 64'(trace), 64'h0DE);
        chk("single_drained", 64'(exp_q.size()), 64'd0);
        chk("single_credits", 64'(dut.credits_q), 64'd10);

        // Round robin with all three sources held.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tag[i] = $urandom;
            len[i] = 8;
        end
        rd_mode = 1'b1;
        plan_writes();
        run_until_drained("rr", 300);

        // Credit stall and single-credit return.
        do_reset();
        tag[0] = 32'h1000;
        len[0] = 30;
        plan_writes();
        repeat (30) tick();
        chk("stall_writes", 64'(wr_count), 64'(DEPTH));
        chk("stall_credits", 64'(last_credits), 64'd0);
        chk("stall_cen", 64'(last_cen), 64'd0);
        chk("stall_busy", 64'(last_busy), 64'd1);
        bus.fifo_rd = 1'b1;
        tick();
        chk("stall_rd_cycle_cen", 64'(last_cen), 64'd0);
        tick();
        chk("stall_one_cen", 64'(last_cen), 64'd1);
        tick();
        chk("stall_after_cen", 64'(last_cen), 64'd0);

        // Simultaneous pop and cen at one credit.
        bus.fifo_rd = 1'b1;
        tick();
        bus.fifo_rd = 1'b1;
        tick();
        chk("simul_cen", 64'(last_cen), 64'd1);
        chk("simul_credits_before", 64'(last_credits), 64'd1);
        tick();
        chk("simul_credits_kept", 64'(last_credits), 64'd1);
        chk("simul_next_cen", 64'(last_cen), 64'd1);
        tick();
        chk("simul_then_stall", 64'(last_cen), 64'd0);

        // Rewind at beat 2 of source 1's grant.
        do_reset();
        tag[0] = 32'hA000;
        tag[1] = 32'hB000;
        len[0] = 10;
        len[1] = 10;
        rd_mode = 1'b1;
        push_exp(0, 0, 4);
        push_exp(1, 0, 2);
        repeat (8) tick();
        bus.rewind = 1'b1;
        tick();
        chk("rewind_no_cen", 64'(last_cen), 64'd0);
        bus.rewind = 1'b0;
        tick();
        chk("rewind_drain_restart", 64'(last_restart), 64'd0);
        chk("rewind_drain_busy", 64'(last_busy), 64'd1);
        chk("rewind_drain_cen", 64'(last_cen), 64'd0);
        tick();
        chk("rewind_restart", 64'(last_restart), 64'h7);
        chk("rewind_restart_cen", 64'(last_cen), 64'd0);
        chk("rewind_queue_done", 64'(exp_q.size()), 64'd0);
        model_last = 2;
        plan_writes();
        tick();
        chk("rewind_restart_once", 64'(last_restart), 64'd0);
        tick();
        chk("rewind_next_grant", 64'(last_cen), 64'd1);
        run_until_drained("rewind", 300);

        // Reset asserted in a cycle with src_cen = 3'b010.
        do_reset();
        tag[0] = 32'hC000;
        tag[1] = 32'hD000;
        len[0] = 10;
        len[1] = 10;
        plan_writes();
        hit         = 1'b0;
        rst_req_cen = 1'b1;
        n = 0;
        while (!hit && n < 40) begin
            tick();
            n++;
        end
        rst_req_cen = 1'b0;
        chk("rst_mid_hit", 64'(hit), 64'd1);
        check_reset_outputs("rst_mid");

        // Randomized loads.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int i = 0; i < 3; i++) begin
                tag[i] = $urandom;
                len[i] = $urandom_range(0, 12);
            end
            rd_mode = 1'b1;
            plan_writes();
            run_until_drained("rand", 400);
            chk("rand_credits", 64'(last_credits), 64'(DEPTH - last_occ_pre));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
